// File: rtl/pr_bus_pkg.sv
// Shared types for the scripted processor-side bus initiator:
// command op codes, FSM states and response word layout.
package pr_bus_pkg;

    typedef enum logic [1:0] {
        OP_WRITE    = 2'b00,
        OP_READ     = 2'b01,
        OP_WAIT_IRQ = 2'b10,
        OP_DELAY    = 2'b11
    } prOp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DELAY,
        ST_RESP
    } prState_t;

    localparam int IRQ_W           = 6;
    localparam int RSP_TIMEOUT_BIT = 31;

    // WAIT_IRQ response word: {timeout flag, 25'b0, hwInt}
    function automatic logic [31:0] waitRspWord(
        input logic             timedOut,
        input logic [IRQ_W-1:0] irq
    );
        logic [31:0] w;
        w = '0;
        w[RSP_TIMEOUT_BIT] = timedOut;
        w[IRQ_W-1:0] = irq;
        return w;
    endfunction

endpackage

// File: rtl/pr_cycle_counter.sv
// Loadable up-counter shared by WAIT and DELAY.
// Ports: clk, rst (async low), clear, enable, limit; match = count==limit-1 (limit!=0).
module pr_cycle_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         match
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    assign match = (limit != '0) && (count == limit - W'(1));

endmodule

// File: rtl/pr_bus_master.sv
// Scripted bus initiator replacing the CPU on the bridge processor port.
// Ports: cmd_* stream in, rsp_* stream out, pr* bridge port, hwInt, busy.
module pr_bus_master
    import pr_bus_pkg::*;
#(
    parameter int TIMEOUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [29:0]      cmd_addr,
    input  logic [3:0]       cmd_be,
    input  logic [31:0]      cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [29:0]      prAddr,
    output logic             prWe,
    output logic [3:0]       prBe,
    output logic [31:0]      prDout,
    input  logic [31:0]      prDin,
    input  logic [IRQ_W-1:0] hwInt,
    output logic             busy
);

    prState_t               state;
    prState_t               stateNext;
    prOp_t                  cmdOp;
    prOp_t                  opReg;
    logic [IRQ_W-1:0]       maskReg;
    logic [TIMEOUT_W-1:0]   limitReg;
    logic [3:0]             beReg;
    logic [31:0]            rspReg;
    logic [31:0]            rspNext;
    logic                   loadRsp;
    logic                   accept;
    logic                   cntMatch;
    logic                   irqHit;
    logic                   waitExpired;
    logic                   delayDone;

    assign cmdOp  = prOp_t'(cmd_op);
    assign accept = cmd_valid && (state == ST_IDLE);
    assign irqHit = |(hwInt & maskReg);

    // Zero timeout with zero mask would never finish; treat as immediate timeout.
    assign waitExpired = cntMatch || ((limitReg == '0) && (maskReg == '0));
    assign delayDone   = cntMatch || (limitReg == '0);

    pr_cycle_counter #(
        .W(TIMEOUT_W)
    ) uCounter (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable ((state == ST_WAIT) || (state == ST_DELAY)),
        .limit  (limitReg),
        .match  (cntMatch)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        loadRsp   = 1'b0;
        rspNext   = rspReg;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    unique case (cmdOp)
                        OP_WRITE, OP_READ: stateNext = ST_ISSUE;
                        OP_WAIT_IRQ:       stateNext = ST_WAIT;
                        OP_DELAY:          stateNext = ST_DELAY;
                        default:           stateNext = ST_IDLE;
                    endcase
                end
            end
            ST_ISSUE: begin
                if (opReg == OP_READ) begin
                    loadRsp   = 1'b1;
                    rspNext   = prDin;
                    stateNext = ST_RESP;
                end else begin
                    stateNext = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (irqHit) begin
                    loadRsp   = 1'b1;
                    rspNext   = waitRspWord(1'b0, hwInt);
                    stateNext = ST_RESP;
                end else if (waitExpired) begin
                    loadRsp   = 1'b1;
                    rspNext   = waitRspWord(1'b1, hwInt);
                    stateNext = ST_RESP;
                end
            end
            ST_DELAY: begin
                if (delayDone) begin
                    stateNext = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opReg    <= OP_WRITE;
            maskReg  <= '0;
            limitReg <= '0;
            beReg    <= '0;
            prAddr   <= '0;
            prDout   <= '0;
            rspReg   <= '0;
        end else begin
            if (accept) begin
                opReg   <= cmdOp;
                maskReg <= cmd_data[IRQ_W-1:0];
                beReg   <= cmd_be;
                if (cmdOp == OP_WAIT_IRQ) begin
                    limitReg <= TIMEOUT_W'(cmd_data[31:16]);
                end else begin
                    limitReg <= TIMEOUT_W'(cmd_data[15:0]);
                end
                // Only bus ops move the address/data lines; others leave them held.
                if ((cmdOp == OP_WRITE) || (cmdOp == OP_READ)) begin
                    prAddr <= cmd_addr;
                    prDout <= cmd_data;
                end
            end
            if (loadRsp) begin
                rspReg <= rspNext;
            end
        end
    end

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_data  = rspReg;
    assign prWe      = (state == ST_ISSUE) && (opReg == OP_WRITE);
    assign prBe      = (state == ST_ISSUE) ? beReg : 4'h0;

endmodule

// File: tb/tb_pr_bus_master.sv
// Self-checking bench for pr_bus_master: directed scenarios with literal
// expectations plus randomized command traffic against a transaction model.
module tb_pr_bus_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [29:0] cmd_addr;
    logic [3:0]  cmd_be;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [29:0] prAddr;
    logic        prWe;
    logic [3:0]  prBe;
    logic [31:0] prDout;
    logic [31:0] prDin;
    logic [5:0]  hwInt;
    logic        busy;

    int total = 0;
    int bad   = 0;

    pr_bus_master #(
        .TIMEOUT_W(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_be    (cmd_be),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .prAddr    (prAddr),
        .prWe      (prWe),
        .prBe      (prBe),
        .prDout    (prDout),
        .prDin     (prDin),
        .hwInt     (hwInt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction model: one command in flight, counted in cycles since
    // acceptance, then an optional response held until consumed.
    logic        mActive = 1'b0;
    logic        mPend   = 1'b0;
    logic [1:0]  mOp     = 2'b00;
    logic [3:0]  mBe     = 4'h0;
    logic [31:0] mData   = '0;
    int          mAge    = 0;
    logic [31:0] mRsp    = '0;
    logic [29:0] mAddr   = '0;
    logic [31:0] mDout   = '0;

    // Observations of the DUT used by the directed literal checks.
    int          cyc         = 0;
    int          acceptCyc   = 0;
    int          lastLat     = -1;
    int          busyRun     = 0;
    logic        sawValid    = 1'b0;
    logic [31:0] lastRspSeen = '0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                check("rst cmd_ready", 32'(cmd_ready), 32'd1);
                check("rst busy", 32'(busy), 32'd0);
                check("rst rsp_valid", 32'(rsp_valid), 32'd0);
                check("rst rsp_data", rsp_data, 32'd0);
                check("rst prAddr", 32'(prAddr), 32'd0);
                check("rst prWe", 32'(prWe), 32'd0);
                check("rst prBe", 32'(prBe), 32'd0);
                check("rst prDout", prDout, 32'd0);
                mActive = 1'b0;
                mPend   = 1'b0;
                mRsp    = '0;
                mAddr   = '0;
                mDout   = '0;
            end else begin
                logic busCycle;
                busCycle = mActive && (mOp[1] == 1'b0) && (mAge == 1);
                check("cmd_ready", 32'(cmd_ready), 32'(!mActive && !mPend));
                check("busy", 32'(busy), 32'(mActive || mPend));
                check("rsp_valid", 32'(rsp_valid), 32'(mPend));
                check("prWe", 32'(prWe), 32'(busCycle && (mOp == 2'b00)));
                check("prBe", 32'(prBe), busCycle ? 32'(mBe) : 32'd0);
                check("prAddr", 32'(prAddr), 32'(mAddr));
                check("prDout", prDout, mDout);
                if (mPend) check("rsp_data", rsp_data, mRsp);

                if (busy) busyRun++;
                if (rsp_valid && !sawValid) begin
                    sawValid = 1'b1;
                    lastLat  = cyc - acceptCyc;
                end

                if (mActive) begin
                    case (mOp)
                        2'b00: mActive = 1'b0;
                        2'b01: begin
                            mRsp    = prDin;
                            mPend   = 1'b1;
                            mActive = 1'b0;
                        end
                        2'b10: begin
                            logic [5:0]  mask;
                            logic [15:0] tmo;
                            mask = mData[5:0];
                            tmo  = mData[31:16];
                            if ((hwInt & mask) != 6'd0) begin
                                mRsp    = {26'd0, hwInt};
                                mPend   = 1'b1;
                                mActive = 1'b0;
                            end else if ((tmo != 0 && mAge == int'(tmo)) ||
                                         (tmo == 0 && mask == 0)) begin
                                mRsp    = {1'b1, 25'd0, hwInt};
                                mPend   = 1'b1;
                                mActive = 1'b0;
                            end else begin
                                mAge++;
                            end
                        end
                        default: begin
                            int n;
                            n = int'(mData[15:0]);
                            if (n == 0) n = 1;
                            if (mAge >= n) mActive = 1'b0;
                            else mAge++;
                        end
                    endcase
                end else if (mPend) begin
                    if (rsp_ready) begin
                        mPend       = 1'b0;
                        lastRspSeen = rsp_data;
                    end
                end else if (cmd_valid) begin
                    mActive   = 1'b1;
                    mAge      = 1;
                    mOp       = cmd_op;
                    mBe       = cmd_be;
                    mData     = cmd_data;
                    acceptCyc = cyc;
                    busyRun   = 0;
                    sawValid  = 1'b0;
                    lastLat   = -1;
                    if (cmd_op[1] == 1'b0) begin
                        mAddr = cmd_addr;
                        mDout = cmd_data;
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic sendCmd(input logic [1:0] op, input logic [29:0] addr,
                           input logic [3:0] be, input logic [31:0] data);
        logic ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_be    = be;
        cmd_data  = data;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        check("cmd accepted in time", 32'(ok), 32'd1);
    endtask

    task automatic waitRsp();
        logic ok;
        ok        = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b0;
        check("rsp arrived in time", 32'(ok), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = '0;
        cmd_be    = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        prDin     = '0;
        hwInt     = '0;
        #1 rst = 1'b0;
        #1;
        check("init cmd_ready", 32'(cmd_ready), 32'd1);
        check("init busy", 32'(busy), 32'd0);
        check("init prWe", 32'(prWe), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Write timer control
        sendCmd(2'b00, 30'h1FC0, 4'hF, 32'h9);
        check("wr prWe", 32'(prWe), 32'd1);
        check("wr prAddr", 32'(prAddr), 32'h1FC0);
        check("wr prDout", prDout, 32'h9);
        check("wr prBe", 32'(prBe), 32'hF);
        @(posedge clk);
        #1;
        check("wr prWe drop", 32'(prWe), 32'd0);
        check("wr cmd_ready back", 32'(cmd_ready), 32'd1);
        check("wr no rsp", 32'(rsp_valid), 32'd0);

        // Read-back
        prDin = 32'h0000_0009;
        sendCmd(2'b01, 30'h1FC0, 4'hF, 32'h0);
        check("rd prWe", 32'(prWe), 32'd0);
        check("rd prBe", 32'(prBe), 32'hF);
        waitRsp();
        check("rd data", lastRspSeen, 32'h9);
        check("rd latency", 32'(lastLat), 32'd2);
        check("rd cmd_ready back", 32'(cmd_ready), 32'd1);

        // Interrupt wait
        hwInt = 6'h00;
        sendCmd(2'b10, 30'h0, 4'h0, {16'd100, 10'd0, 6'h01});
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        check("irq still waiting", 32'(rsp_valid), 32'd0);
        hwInt = 6'h01;
        waitRsp();
        hwInt = 6'h00;
        check("irq data", lastRspSeen, 32'h0000_0001);
        check("irq latency", 32'(lastLat), 32'd22);

        // Timeout with unmasked line high
        hwInt = 6'h01;
        sendCmd(2'b10, 30'h0, 4'h0, {16'd10, 10'd0, 6'h04});
        waitRsp();
        hwInt = 6'h00;
        check("tmo data", lastRspSeen, 32'h8000_0001);
        check("tmo latency", 32'(lastLat), 32'd11);

        // Backpressure on a read response
        prDin = 32'hA5C3_0F96;
        sendCmd(2'b01, 30'h123, 4'h3, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            prDin = $urandom;
            check("bp rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp rsp_data", rsp_data, 32'hA5C3_0F96);
            check("bp cmd_ready", 32'(cmd_ready), 32'd0);
        end
        waitRsp();
        check("bp data", lastRspSeen, 32'hA5C3_0F96);

        // Delay of three cycles
        sendCmd(2'b11, 30'h0, 4'h0, 32'd3);
        for (int i = 0; i < 100 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        check("delay busy cycles", 32'(busyRun), 32'd3);

        // Reset in the middle of a wait
        hwInt = 6'h00;
        sendCmd(2'b10, 30'h0, 4'h0, {16'd50, 16'd0});
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("mid-wait busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst busy", 32'(busy), 32'd0);
        check("arst cmd_ready", 32'(cmd_ready), 32'd1);
        check("arst rsp_data", rsp_data, 32'd0);
        check("arst prAddr", 32'(prAddr), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        sendCmd(2'b00, 30'h55, 4'h5, 32'hDEAD);
        check("post-rst prWe", 32'(prWe), 32'd1);
        check("post-rst prAddr", 32'(prAddr), 32'h55);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            logic [1:0]  op;
            logic [5:0]  mask;
            op        = 2'($urandom_range(0, 3));
            mask      = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_op    = op;
            cmd_addr  = 30'($urandom);
            cmd_be    = 4'($urandom);
            case (op)
                2'b10:   cmd_data = {16'($urandom_range(0, 30)), 10'($urandom), mask};
                2'b11:   cmd_data = {16'($urandom), 16'($urandom_range(0, 12))};
                default: cmd_data = $urandom;
            endcase
            rsp_ready = $urandom_range(0, 1) == 1;
            hwInt     = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'd0;
            prDin     = $urandom;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        hwInt     = 6'h3F;
        for (int i = 0; i < 200 && !cmd_ready; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain idle", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pr_bus_master.md
# pr_bus_master

Scripted processor-side bus initiator for the mini machine. It accepts a stream of bus commands (write, read, wait-for-interrupt, delay) and drives the bridge's processor port (`prAddr/prWe/prBe/prDout`), returning read data and interrupt status. It takes the CPU's place, so the bridge, timer and future peripherals can be brought up and regressed without the MIPS core.

## Interface
- `TIMEOUT_W`, 16: width of the wait/delay cycle counters.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when both high.
- `cmd_op`  in  2  00 WRITE, 01 READ, 10 WAIT_IRQ, 11 DELAY.
- `cmd_addr`  in  30  word address [31:2].
- `cmd_be`  in  4  byte enables.
- `cmd_data`  in  32  write data; WAIT_IRQ: [5:0] mask, [31:16] timeout; DELAY: [15:0] cycles.
- `rsp_valid`  out  1  response available (READ, WAIT_IRQ only).
- `rsp_ready`  in  1  response consumed when both high.
- `rsp_data`  out  32  read data, or {timeout flag, 25'b0, hwInt} for WAIT_IRQ.
- `prAddr`  out  30  bridge address [31:2].
- `prWe`  out  1  write strobe.
- `prBe`  out  4  byte enables.
- `prDout`  out  32  write data.
- `prDin`  in  32  read data from bridge (combinational in the address cycle).
- `hwInt`  in  6  interrupt lines from bridge.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, DELAY, RESP.
- IDLE: `cmd_ready`=1. On handshake, latch the whole command and go to ISSUE (WRITE/READ), WAIT (WAIT_IRQ) or DELAY (DELAY).
- ISSUE, exactly one cycle: drive `prAddr`=addr, `prBe`=be, `prDout`=data, `prWe`=(op==WRITE).
  - WRITE: go to IDLE.
  - READ: register `prDin` into `rsp_data` at the end of this cycle, then go to RESP.
- WAIT: counter starts at 0 and increments each cycle. Every cycle, first evaluate `hwInt & mask`:
  - Nonzero: `rsp_data`={1'b0,25'b0,hwInt}, go to RESP.
  - Else, if timeout!=0 and counter==timeout-1: `rsp_data`={1'b1,25'b0,hwInt}, go to RESP.
  - Interrupt wins over timeout in the same cycle.
  - mask==0 with timeout==0: respond next cycle with the flag set (no infinite hang).
  - mask==0 with timeout!=0: pure timed wait.
- DELAY: remain N cycles (N=cmd_data[15:0]), then IDLE. N=0 returns to IDLE after one cycle in DELAY.
- RESP: `rsp_valid`=1, `rsp_data` stable until `rsp_ready`, then IDLE. No new command is accepted while in RESP.
- Outside ISSUE: `prWe`=0, `prBe`=0; `prAddr` and `prDout` hold their last driven values.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_data`=0, `prAddr`=0, `prWe`=0, `prBe`=0, `prDout`=0, counters 0.
- Reset mid-operation clears state immediately. `prWe` drops asynchronously, and any pending response is discarded.
- WRITE: accepted at edge t, `prWe` high during cycle t..t+1, `cmd_ready` high again at t+2. Sustained throughput is 1 write per 2 cycles.
- READ: accepted at t, address cycle t+1, `rsp_valid` from t+2. With `rsp_ready` held high, `cmd_ready` returns at t+3.
- WAIT_IRQ: if an interrupt is already asserted, `rsp_valid` 2 cycles after acceptance. Timeout T gives `rsp_valid` T+1 cycles after acceptance.
- `hwInt` is sampled synchronously with no internal synchronizer; the bridge provides registered lines.

## Structure
- `pr_bus_pkg`: op codes, state enum, rsp_data timeout-flag bit position (31).
- One sub-module, `pr_cycle_counter`: loadable `TIMEOUT_W` up-counter with terminal-match output, shared by WAIT and DELAY.
- The remainder is a single FSM plus command/response registers. Target is about 200 lines of RTL.

## Test plan
- Write timer control: WRITE addr 0x7F00>>2, be 4'hF, data 0x9 -> one-cycle `prWe`, `prAddr`=0x1FC0, `prDout`=0x9, no `rsp_valid`.
- Read-back: READ of the same address with `prDin`=0x0000_0009 -> `rsp_data`=0x9, `rsp_valid` 2 cycles after acceptance, `prWe`=0 throughout.
- Interrupt wait: WAIT_IRQ mask 0x01, timeout 100; raise `hwInt`[0] after 20 cycles -> `rsp_data`=0x0000_0001 (flag clear).
- Timeout: WAIT_IRQ mask 0x04, timeout 10, `hwInt`=0x01 -> `rsp_data`=0x8000_0001, `rsp_valid` 11 cycles after acceptance.
- Backpressure/delay: READ with `rsp_ready` low for 5 cycles -> `rsp_data` stable and `cmd_ready` low throughout. Then DELAY 3 -> `busy` high 3 cycles.
- Reset mid-WAIT: deassert `rst` during WAIT -> all outputs return to reset values immediately. After release, the next command is accepted normally.
